// File: rtl/access_grant_ctrl.sv
// Access grant controller: turns detection pulses into bounded grant windows,
// with cooldown after each grant and timed lockout after repeated failures.
module access_grant_ctrl #(
    parameter int GRANT_CYCLES = 8,
    parameter int COOL_CYCLES  = 4,
    parameter int MAX_FAILS    = 3,
    parameter int LOCK_CYCLES  = 16,
    localparam int FW = $clog2(MAX_FAILS + 1)
) (
    input  logic          clk,
    input  logic          RESET,
    input  logic          det_in,
    input  logic          attempt_end,
    input  logic          grant_ack,
    output logic          grant,
    output logic          grant_timeout,
    output logic          locked,
    output logic [FW-1:0] fail_cnt,
    output logic [1:0]    st
);

    localparam int TGC  = (GRANT_CYCLES > COOL_CYCLES) ? GRANT_CYCLES : COOL_CYCLES;
    localparam int TMAX = (TGC > LOCK_CYCLES) ? TGC : LOCK_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0] G_LAST = TW'(GRANT_CYCLES - 1);
    localparam logic [TW-1:0] C_LAST = TW'(COOL_CYCLES - 1);
    localparam logic [TW-1:0] L_LAST = TW'(LOCK_CYCLES - 1);
    localparam logic [FW-1:0] F_MAX  = FW'(MAX_FAILS);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT    = 2'd1,
        COOLDOWN = 2'd2,
        LOCKOUT  = 2'd3
    } state_t;

    state_t        state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic [FW-1:0] fail_n;
    logic          gto_n;

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            state         <= IDLE;
            timer         <= '0;
            fail_cnt      <= '0;
            grant_timeout <= 1'b0;
        end else begin
            state         <= state_n;
            timer         <= timer_n;
            fail_cnt      <= fail_n;
            grant_timeout <= gto_n;
        end
    end

    always_comb begin
        state_n = state;
        fail_n  = fail_cnt;
        gto_n   = 1'b0;
        case (state)
            IDLE: begin
                if (det_in) begin
                    state_n = GRANT;
                    fail_n  = '0;
                end else if (attempt_end) begin
                    fail_n = fail_cnt + FW'(1);
                    if (fail_n == F_MAX) state_n = LOCKOUT;
                end
            end
            GRANT: begin
                if (grant_ack) begin
                    state_n = COOLDOWN;
                end else if (timer == G_LAST) begin
                    state_n = COOLDOWN;
                    gto_n   = 1'b1;
                end
            end
            COOLDOWN: begin
                if (timer == C_LAST) state_n = IDLE;
            end
            LOCKOUT: begin
                if (timer == L_LAST) begin
                    state_n = IDLE;
                    fail_n  = '0;
                end
            end
            default: begin
                state_n = IDLE;
                fail_n  = '0;
            end
        endcase
        // timer restarts on every state entry and idles at zero
        if (state_n != state || state_n == IDLE) timer_n = '0;
        else timer_n = timer + TW'(1);
    end

    assign grant  = (state == GRANT);
    assign locked = (state == LOCKOUT);
    assign st     = state;

    a_excl: assert property (@(posedge clk) disable iff (!RESET)
        !(grant && locked));
    a_gto: assert property (@(posedge clk) disable iff (!RESET)
        grant_timeout |-> $past(state) == GRANT);
    a_fail: assert property (@(posedge clk) disable iff (!RESET)
        fail_cnt <= F_MAX);
    a_run: assert property (@(posedge clk) disable iff (!RESET)
        (state == GRANT) |-> (int'(timer) < GRANT_CYCLES));
    a_entry: assert property (@(posedge clk) disable iff (!RESET)
        (state == COOLDOWN || state == LOCKOUT) |=> state != GRANT);

endmodule

// File: tb/tb_access_grant_ctrl.sv
// Directed bench for access_grant_ctrl with a remaining-cycle behavioural
// model compared every cycle, plus hand-computed literal checks.
module tb_access_grant_ctrl;

    localparam int GC = 8;
    localparam int CC = 4;
    localparam int MF = 3;
    localparam int LC = 16;

    logic       clk = 1'b0;
    logic       RESET = 1'b0;
    logic       det_in = 1'b0;
    logic       attempt_end = 1'b0;
    logic       grant_ack = 1'b0;
    logic       grant;
    logic       grant_timeout;
    logic       locked;
    logic [1:0] fail_cnt;
    logic [1:0] st;

    int tests = 0;
    int fails = 0;

    access_grant_ctrl #(
        .GRANT_CYCLES(GC), .COOL_CYCLES(CC),
        .MAX_FAILS(MF), .LOCK_CYCLES(LC)
    ) dut (
        .clk(clk), .RESET(RESET),
        .det_in(det_in), .attempt_end(attempt_end),
        .grant_ack(grant_ack), .grant(grant),
        .grant_timeout(grant_timeout), .locked(locked),
        .fail_cnt(fail_cnt), .st(st)
    );

    always #5 clk = ~clk;

    // model: remaining cooldown/lockout cycles, grant cycles used
    int m_gact, m_used, m_cool, m_lock, m_fails;
    bit m_gto;

    always @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            m_gact = 0; m_used = 0; m_cool = 0;
            m_lock = 0; m_fails = 0; m_gto = 0;
        end else begin
            m_gto = 0;
            if (m_lock > 0) begin
                m_lock--;
                if (m_lock == 0) m_fails = 0;
            end else if (m_cool > 0) begin
                m_cool--;
            end else if (m_gact != 0) begin
                m_used++;
                if (grant_ack) begin
                    m_gact = 0; m_cool = CC;
                end else if (m_used == GC) begin
                    m_gact = 0; m_cool = CC; m_gto = 1;
                end
            end else if (det_in) begin
                m_gact = 1; m_used = 0; m_fails = 0;
            end else if (attempt_end) begin
                m_fails++;
                if (m_fails == MF) m_lock = LC;
            end
        end
    end

    function automatic int exp_st();
        if (m_lock > 0) return 3;
        if (m_cool > 0) return 2;
        if (m_gact != 0) return 1;
        return 0;
    endfunction

    always @(negedge clk) begin
        if (RESET) begin
            tests++;
            if (grant !== (m_gact != 0) || locked !== (m_lock > 0) ||
                grant_timeout !== m_gto || int'(fail_cnt) != m_fails ||
                int'(st) != exp_st() || $isunknown({grant, locked, fail_cnt, st})) begin
                fails++;
                $display("FAIL model t=%0t got g=%b l=%b to=%b f=%0d st=%0d want g=%0d l=%0d to=%0d f=%0d st=%0d",
                         $time, grant, locked, grant_timeout, fail_cnt, st,
                         m_gact != 0, m_lock > 0, m_gto, m_fails, exp_st());
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic pulse_det();
        det_in = 1'b1; step(); det_in = 1'b0;
    endtask

    task automatic pulse_fail();
        attempt_end = 1'b1; step(); attempt_end = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (st != 2'd0 && n < 40) begin n++; step(); end
        chk(name, int'(st), 0);
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_out"}, int'({grant, grant_timeout, locked}), 0);
        chk({name, "_st"}, int'(st), 0);
        chk({name, "_fc"}, int'(fail_cnt), 0);
    endtask

    initial begin
        int n;
        step(); step();
        chk_zero("reset");
        RESET = 1'b1;
        step(); step();

        // full-length grant, timeout pulse, cooldown
        pulse_det();
        n = 0;
        while (grant && n < 20) begin n++; step(); end
        chk("grant_len", n, GC);
        chk("timeout_pulse", int'(grant_timeout), 1);
        chk("cool_st", int'(st), 2);
        n = 0;
        while (st == 2'd2 && n < 20) begin n++; step(); end
        chk("cool_len", n, CC);
        chk("timeout_clear", int'(grant_timeout), 0);

        // ack on third grant cycle
        pulse_det();
        step(); step();
        chk("ack3_grant", int'(grant), 1);
        grant_ack = 1'b1; step(); grant_ack = 1'b0;
        chk("ack3_st", int'(st), 2);
        chk("ack3_noto", int'(grant_timeout), 0);
        step(); step(); step();
        chk("ack3_cool_end", int'(st), 2);
        step();
        chk("ack3_idle", int'(st), 0);

        // three failures into lockout, detection ignored mid-lockout
        for (int i = 1; i <= MF; i++) begin
            pulse_fail();
            chk("fail_cnt", int'(fail_cnt), i);
        end
        chk("locked", int'(locked), 1);
        n = 0;
        while (locked && n < 40) begin
            n++;
            det_in = (n == 5);
            step();
        end
        det_in = 1'b0;
        chk("lock_len", n, LC);
        chk("lock_exit_fc", int'(fail_cnt), 0);
        chk("lock_exit_g", int'(grant), 0);

        // detection clears failure count; det wins over attempt_end
        pulse_fail(); pulse_fail();
        chk("two_fails", int'(fail_cnt), 2);
        pulse_det();
        chk("det_clr_g", int'(grant), 1);
        chk("det_clr_fc", int'(fail_cnt), 0);
        wait_idle("idle_a");
        pulse_fail();
        det_in = 1'b1; attempt_end = 1'b1; step();
        det_in = 1'b0; attempt_end = 1'b0;
        chk("both_g", int'(grant), 1);
        chk("both_fc", int'(fail_cnt), 0);

        // ack on first grant cycle, detection dropped in cooldown
        grant_ack = 1'b1; step(); grant_ack = 1'b0;
        chk("ack1_st", int'(st), 2);
        step();
        pulse_det();
        chk("cool_drop", int'(grant), 0);
        wait_idle("idle_b");
        pulse_det();
        chk("regrant", int'(grant), 1);

        // ack on final cycle suppresses timeout
        for (int i = 1; i < GC; i++) step();
        chk("last_grant", int'(grant), 1);
        grant_ack = 1'b1; step(); grant_ack = 1'b0;
        chk("last_ack_noto", int'(grant_timeout), 0);
        wait_idle("idle_c");

        // async reset mid-grant
        pulse_det(); step(); step();
        #2 RESET = 1'b0;
        #1 chk_zero("rst_grant");
        step(); RESET = 1'b1; step();

        // async reset mid-lockout
        for (int i = 0; i < MF; i++) pulse_fail();
        step(); step();
        chk("pre_rst_lock", int'(locked), 1);
        #2 RESET = 1'b0;
        #1 chk_zero("rst_lock");
        step(); RESET = 1'b1; step(); step();
        chk("post_rst_st", int'(st), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
